keypad_debounce_sync: RTL

//  Multi-channel keypad input conditioner: 2-flop synchroniser plus per-channel

---
 rtl/keypad_pkg.sv | 18 +
 rtl/keypad_debounce_sync_channel.sv | 144 ++++++++++++++
 rtl/keypad_debounce_sync.sv | 60 ++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types, defaults and width helper for the keypad debouncer
package keypad_pkg;

   typedef enum logic {
      DB_STABLE  = 1'b0,
      DB_PENDING = 1'b1
   } db_state_t;

   localparam int DEF_STABLE_TICKS  = 16;
   localparam int DEF_REPEAT_DELAY  = 500;
   localparam int DEF_REPEAT_PERIOD = 100;

   // Bits needed to hold the values 0..n
   function automatic int cnt_width(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/keypad_debounce_sync_channel.sv
// rtl/keypad_debounce_sync_channel.sv - one debounce channel (level, counter, optional auto-repeat via KEYPAD_DEBOUNCE_AUTOREPEAT_EN)
module debounce_channel
   import keypad_pkg::*;
#(
   parameter int STABLE_TICKS  = DEF_STABLE_TICKS,
   parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
   input  logic i_clock,
   input  logic i_reset_n,
   input  logic i_tick,
   input  logic i_lvl,
   output logic o_level,
   output logic o_press,
   output logic o_release
);

   localparam int CW = cnt_width(STABLE_TICKS);
   localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

   if (STABLE_TICKS < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
      $error("debounce_channel: STABLE_TICKS, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
   end

   logic          r_level;
   logic [CW-1:0] r_cnt;
   logic          r_press;
   logic          r_release;

   db_state_t     w_state;
   logic          w_accept;
   logic [CW-1:0] w_cnt_nxt;
   logic          w_level_nxt;
   logic          w_press_nxt;
   logic          w_release_nxt;
   logic          w_rep_fire;

   // Channel is pending whenever the synchronised pin disagrees with the accepted level
   always_comb begin
      w_state = (i_lvl != r_level) ? DB_PENDING : DB_STABLE;
   end

   // Next-state: count ticks while pending, accept on the last one, reset on bounce-back
   always_comb begin
      w_accept  = 1'b0;
      w_cnt_nxt = r_cnt;
      case (w_state)
         DB_STABLE: begin
            w_cnt_nxt = '0;
         end
         DB_PENDING: begin
            if (i_tick) begin
               if (r_cnt == CNT_LAST) begin
                  w_accept  = 1'b1;
                  w_cnt_nxt = '0;
               end else begin
                  w_cnt_nxt = r_cnt + CW'(1);
               end
            end
         end
         default: begin
            w_cnt_nxt = '0;
         end
      endcase
   end

`ifdef KEYPAD_DEBOUNCE_AUTOREPEAT_EN
   localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RW   = cnt_width(RMAX);
   localparam logic [RW-1:0] R_DELAY  = RW'(REPEAT_DELAY);
   localparam logic [RW-1:0] R_PERIOD = RW'(REPEAT_PERIOD);

   logic [RW-1:0] r_rcnt;
   logic          r_rphase;
   logic [RW-1:0] w_rcnt_nxt;
   logic [RW-1:0] w_rcnt_inc;
   logic [RW-1:0] w_rtarget;
   logic          w_rphase_nxt;

   // Repeat timer: first fire after REPEAT_DELAY held ticks, then every REPEAT_PERIOD
   always_comb begin
      w_rep_fire   = 1'b0;
      w_rcnt_nxt   = r_rcnt;
      w_rphase_nxt = r_rphase;
      w_rcnt_inc   = r_rcnt + RW'(1);
      w_rtarget    = r_rphase ? R_PERIOD : R_DELAY;
      if (w_accept || !r_level) begin
         w_rcnt_nxt   = '0;
         w_rphase_nxt = 1'b0;
      end else if (i_tick) begin
         if (w_rcnt_inc == w_rtarget) begin
            w_rep_fire   = 1'b1;
            w_rcnt_nxt   = '0;
            w_rphase_nxt = 1'b1;
         end else begin
            w_rcnt_nxt = w_rcnt_inc;
         end
      end
   end

   // Repeat timer registers
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_rcnt   <= '0;
         r_rphase <= 1'b0;
      end else begin
         r_rcnt   <= w_rcnt_nxt;
         r_rphase <= w_rphase_nxt;
      end
   end
`else
   // Without auto-repeat a held key produces only the acceptance pulse
   always_comb begin
      w_rep_fire = 1'b0;
   end
`endif

   // Output decode: new level on acceptance, direction picks press or release pulse
   always_comb begin
      w_level_nxt   = w_accept ? i_lvl : r_level;
      w_press_nxt   = (w_accept & i_lvl) | w_rep_fire;
      w_release_nxt = w_accept & ~i_lvl;
   end

   // Level, counter and pulse registers; reset discards any pending change
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_level   <= 1'b0;
         r_cnt     <= '0;
         r_press   <= 1'b0;
         r_release <= 1'b0;
      end else begin
         r_level   <= w_level_nxt;
         r_cnt     <= w_cnt_nxt;
         r_press   <= w_press_nxt;
         r_release <= w_release_nxt;
      end
   end

   assign o_level   = r_level;
   assign o_press   = r_press;
   assign o_release = r_release;

endmodule

// File: rtl/keypad_debounce_sync.sv
// rtl/keypad_debounce_sync.sv - keypad synchroniser plus per-key debounce; auto-repeat with KEYPAD_DEBOUNCE_AUTOREPEAT_EN
module keypad_debounce_sync
   import keypad_pkg::*;
#(
   parameter int NUM_KEYS      = 4,
   parameter int STABLE_TICKS  = DEF_STABLE_TICKS,
   parameter int ACTIVE_LOW    = 0,
   parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic                sample_tick,
   input  logic [NUM_KEYS-1:0] button_in,
   output logic [NUM_KEYS-1:0] button_out,
   output logic [NUM_KEYS-1:0] press_pulse,
   output logic [NUM_KEYS-1:0] release_pulse,
   output logic                any_pressed
);

   // Pin level of a released key; also the value the synchroniser resets to
   localparam logic [NUM_KEYS-1:0] IDLE_PINS =
      (ACTIVE_LOW != 0) ? {NUM_KEYS{1'b1}} : {NUM_KEYS{1'b0}};

   logic [NUM_KEYS-1:0] r_sync1;
   logic [NUM_KEYS-1:0] r_sync2;
   logic [NUM_KEYS-1:0] w_lvl;

   // Two-flop synchroniser shared by all channels
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1 <= IDLE_PINS;
         r_sync2 <= IDLE_PINS;
      end else begin
         r_sync1 <= button_in;
         r_sync2 <= r_sync1;
      end
   end

   assign w_lvl = r_sync2 ^ IDLE_PINS;

   for (genvar g = 0; g < NUM_KEYS; g++) begin : g_chan
      debounce_channel #(
         .STABLE_TICKS  (STABLE_TICKS),
         .REPEAT_DELAY  (REPEAT_DELAY),
         .REPEAT_PERIOD (REPEAT_PERIOD)
      ) u_chan (
         .i_clock   (clock),
         .i_reset_n (reset_n),
         .i_tick    (sample_tick),
         .i_lvl     (w_lvl[g]),
         .o_level   (button_out[g]),
         .o_press   (press_pulse[g]),
         .o_release (release_pulse[g])
      );
   end

   assign any_pressed = |button_out;

endmodule
